// File: rtl/ctx_mem_arbiter.sv
// ctx_mem_arbiter
// Shares one memory port between the core data interface and the RTOS
// context save/restore engine. Granted transactions are tagged in a small
// in-order FIFO so that each memory response is routed back to its owner.
//
// Build option: CTX_MEM_ARB_STARVE_EN adds a starvation counter. Once context
// traffic has lost to the core STARVE_LIMIT times, context requests get
// priority until one of them is granted.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | arbitrate combinationally among the current requesters
// LOCKED | request shown but not granted; owner and mem_* attributes frozen

module ctx_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        core_req_i,
    output logic        core_gnt_o,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,

    input  logic        ctx_wr_valid_i,
    input  logic [31:0] ctx_wr_addr_i,
    input  logic [31:0] ctx_wr_data_i,
    output logic        ctx_wr_ack_o,

    input  logic        ctx_rd_valid_i,
    input  logic [31:0] ctx_rd_addr_i,
    output logic        ctx_rd_ack_o,
    output logic        ctx_rd_resp_valid_o,
    output logic [31:0] ctx_rd_resp_data_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        err_unexp_rvalid_o
);

    typedef enum logic [1:0] {
        TAG_CORE = 2'd0,
        TAG_WR   = 2'd1,
        TAG_RD   = 2'd2
    } tag_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam logic [2:0] FIFO_DEPTH = 3'(MAX_OUTSTANDING);
    localparam logic [1:0] PTR_LAST   = 2'(MAX_OUTSTANDING - 1);

    state_e      state_q, state_d;

    // attributes frozen while LOCKED
    tag_e        lock_owner_q;
    logic        lock_we_q;
    logic [3:0]  lock_be_q;
    logic [31:0] lock_addr_q;
    logic [31:0] lock_wdata_q;

    // tag FIFO; storage sized for the largest legal depth, pointers wrap at depth-1
    tag_e        tag_mem [0:3];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;

    logic        err_q;

    tag_e        arb_owner;
    logic        arb_valid;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    tag_e        mem_owner;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        issue_ok;
    logic        starve_active;
    tag_e        head_tag;

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == PTR_LAST) ? 2'd0 : ptr + 2'd1;
    endfunction

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == FIFO_DEPTH);
    assign pop        = mem_rvalid_i & ~fifo_empty;
    // a response retiring this cycle frees the slot a new grant would take
    assign issue_ok   = ~fifo_full | pop;
    assign push       = mem_req_o & mem_gnt_i;
    assign head_tag   = tag_mem[rd_ptr_q];

`ifdef CTX_MEM_ARB_STARVE_EN
    logic [7:0] starve_cnt_q;

    assign starve_active = (starve_cnt_q >= 8'(STARVE_LIMIT));

    // count IDLE cycles where the core beats a pending context offer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= 8'd0;
        end else if (ctx_wr_ack_o || ctx_rd_ack_o) begin
            starve_cnt_q <= 8'd0;
        end else if (state_q == ST_IDLE && mem_req_o && mem_owner == TAG_CORE &&
                     (ctx_wr_valid_i || ctx_rd_valid_i) && starve_cnt_q != 8'hFF) begin
            starve_cnt_q <= starve_cnt_q + 8'd1;
        end
    end
`else
    assign starve_active = 1'b0;
`endif

    // priority select among current requesters
    always_comb begin
        arb_valid = 1'b0;
        arb_owner = TAG_CORE;
        if (starve_active) begin
            if (ctx_wr_valid_i) begin
                arb_valid = 1'b1;
                arb_owner = TAG_WR;
            end else if (ctx_rd_valid_i) begin
                arb_valid = 1'b1;
                arb_owner = TAG_RD;
            end else if (core_req_i) begin
                arb_valid = 1'b1;
                arb_owner = TAG_CORE;
            end
        end else begin
            if (core_req_i) begin
                arb_valid = 1'b1;
                arb_owner = TAG_CORE;
            end else if (ctx_wr_valid_i) begin
                arb_valid = 1'b1;
                arb_owner = TAG_WR;
            end else if (ctx_rd_valid_i) begin
                arb_valid = 1'b1;
                arb_owner = TAG_RD;
            end
        end
    end

    // request attributes of the arbitration winner
    always_comb begin
        sel_we    = 1'b0;
        sel_be    = 4'hF;
        sel_addr  = 32'd0;
        sel_wdata = 32'd0;
        case (arb_owner)
            TAG_CORE: begin
                sel_we    = core_we_i;
                sel_be    = core_be_i;
                sel_addr  = core_addr_i;
                sel_wdata = core_wdata_i;
            end
            TAG_WR: begin
                sel_we    = 1'b1;
                sel_addr  = ctx_wr_addr_i;
                sel_wdata = ctx_wr_data_i;
            end
            TAG_RD: begin
                sel_addr  = ctx_rd_addr_i;
            end
            default: begin
                sel_we    = 1'b0;
            end
        endcase
    end

    // next state and memory-side outputs
    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        mem_owner   = TAG_CORE;
        case (state_q)
            ST_IDLE: begin
                // rst_ni gating keeps mem_req_o low for the whole reset window
                if (rst_ni && arb_valid && issue_ok) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = sel_we;
                    mem_be_o    = sel_be;
                    mem_addr_o  = sel_addr;
                    mem_wdata_o = sel_wdata;
                    mem_owner   = arb_owner;
                    if (!mem_gnt_i) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                mem_req_o   = 1'b1;
                mem_we_o    = lock_we_q;
                mem_be_o    = lock_be_q;
                mem_addr_o  = lock_addr_q;
                mem_wdata_o = lock_wdata_q;
                mem_owner   = lock_owner_q;
                if (mem_gnt_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign core_gnt_o   = push & (mem_owner == TAG_CORE);
    assign ctx_wr_ack_o = push & (mem_owner == TAG_WR);
    assign ctx_rd_ack_o = push & (mem_owner == TAG_RD);

    // responses go straight through to whoever owns the FIFO head; write tags are dropped
    assign core_rvalid_o       = pop & (head_tag == TAG_CORE);
    assign core_rdata_o        = mem_rdata_i;
    assign ctx_rd_resp_valid_o = pop & (head_tag == TAG_RD);
    assign ctx_rd_resp_data_o  = mem_rdata_i;

    assign err_unexp_rvalid_o = err_q;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // freeze the ungranted request so a withdrawing requester cannot disturb it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_owner_q <= TAG_CORE;
            lock_we_q    <= 1'b0;
            lock_be_q    <= 4'h0;
            lock_addr_q  <= 32'd0;
            lock_wdata_q <= 32'd0;
        end else if (state_q == ST_IDLE && mem_req_o && !mem_gnt_i) begin
            lock_owner_q <= mem_owner;
            lock_we_q    <= mem_we_o;
            lock_be_q    <= mem_be_o;
            lock_addr_q  <= mem_addr_o;
            lock_wdata_q <= mem_wdata_o;
        end
    end

    // tag storage; contents are only meaningful below count_q
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= mem_owner;
        end
    end

    // tag FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // sticky flag for a response with nothing outstanding
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (mem_rvalid_i && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: doc/ctx_mem_arbiter.md
CTX_MEM_ARBITER -- requirements
Module: ctx_mem_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2: memory transactions granted but not yet answered, range 1..4.
REQ-002 Parameter STARVE_LIMIT, default 8: wait cycles before context traffic is forced ahead of the core, range 1..255.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 core_req_i / core_gnt_o  in/out  1/1  core data request and grant.
REQ-006 core_we_i, core_be_i, core_addr_i, core_wdata_i  in  1/4/32/32  core request attributes.
REQ-007 core_rvalid_o, core_rdata_o  out  1/32  core response.
REQ-008 ctx_wr_valid_i, ctx_wr_addr_i, ctx_wr_data_i  in  1/32/32  RTOS-unit context-save write offer.
REQ-009 ctx_wr_ack_o  out  1  one-cycle pulse: context write accepted by memory.
REQ-010 ctx_rd_valid_i, ctx_rd_addr_i  in  1/32  RTOS-unit context-restore read offer.
REQ-011 ctx_rd_ack_o  out  1  one-cycle pulse: context read accepted by memory.
REQ-012 ctx_rd_resp_valid_o, ctx_rd_resp_data_o  out  1/32  context read response.
REQ-013 mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/1/4/32/32  shared memory request.
REQ-014 mem_gnt_i, mem_rvalid_i, mem_rdata_i  in  1/1/32  shared memory grant and response; exactly one rvalid per granted transaction, in order.
REQ-015 err_unexp_rvalid_o  out  1  sticky flag: a response arrived with no transaction outstanding.

Function
REQ-016 The FSM SHALL have two states. IDLE: arbitrate combinationally among the current requesters. LOCKED: mem_req_o was high without mem_gnt_i, so hold the owner and all mem_* attributes stable.
REQ-017 Transitions: IDLE->LOCKED on mem_req_o & ~mem_gnt_i; LOCKED->IDLE on mem_gnt_i; IDLE stays IDLE on a grant or when no requester is present.
REQ-018 Default priority SHALL be core > ctx write > ctx read; a new arbitration happens only in IDLE.
REQ-019 Context writes SHALL drive mem_we_o=1 and mem_be_o=4'hF. Context reads SHALL drive mem_we_o=0 and mem_be_o=4'hF.
REQ-020 On mem_gnt_i, the arbiter SHALL pulse exactly one of core_gnt_o, ctx_wr_ack_o or ctx_rd_ack_o, matching the owner, in the same cycle, and push the owner tag into the tag FIFO.
REQ-021 On mem_rvalid_i, the arbiter SHALL pop the tag FIFO and route the response with zero latency:
- core tag: core_rvalid_o plus core_rdata_o.
- ctx-read tag: ctx_rd_resp_valid_o plus ctx_rd_resp_data_o.
- ctx-write tag: consumed silently.
REQ-022 No new mem_req_o SHALL be raised while the FIFO holds MAX_OUTSTANDING entries, unless mem_rvalid_i pops an entry in the same cycle.
REQ-023 A simultaneous push and pop SHALL leave the count unchanged. A pointer at MAX_OUTSTANDING-1 SHALL wrap to 0.
REQ-024 mem_rvalid_i arriving with an empty FIFO SHALL set err_unexp_rvalid_o, assert no response output, and leave the count at 0.
REQ-025 A requester that withdraws its request while the FSM is LOCKED SHALL NOT change mem_* (the request must stay stable until granted).

Reset
REQ-026 While rst_ni=0, the block SHALL hold:
- FSM in IDLE; FIFO count and pointers at 0; starvation counter at 0; err_unexp_rvalid_o=0.
- mem_req_o=0 and every grant, ack and response-valid output at 0.
REQ-027 Reset asserted mid-transaction SHALL discard all outstanding tags; responses arriving after reset release SHALL set err_unexp_rvalid_o.

Configuration
REQ-028 With CTX_MEM_ARB_STARVE_EN defined:
- An 8-bit counter SHALL increment each IDLE cycle in which a ctx offer is pending and the core wins.
- When the counter reaches STARVE_LIMIT, priority SHALL become ctx write > ctx read > core until a ctx grant occurs, which clears the counter.
REQ-029 Without CTX_MEM_ARB_STARVE_EN, the counter SHALL be absent and fixed priority REQ-018 SHALL always apply.

Verification
REQ-030 Sequence: core read 0x100 and ctx write 0x2000/0xDEADBEEF offered together, mem_gnt_i held at 1. Required response: core granted cycle 0, ctx_wr_ack_o cycle 1, mem_we_o=1 on cycle 1.
REQ-031 Sequence: ctx read 0x3000 issued, mem_gnt_i low for 3 cycles, and core_req_i rises on cycle 1. Required response: mem_addr_o stays 0x3000 until the grant; the core is served afterwards.
REQ-032 Sequence: MAX_OUTSTANDING=2, two core reads granted, no rvalid. Required response: mem_req_o=0 until rvalid; when rvalid arrives, the third request issues in that same cycle.
REQ-033 Sequence: ctx write then ctx read then core read granted back-to-back; rvalids return 0x0, 0x11, 0x22. Required response: first rvalid dropped, ctx_rd_resp_data_o=0x11, core_rdata_o=0x22.
REQ-034 Sequence: CTX_MEM_ARB_STARVE_EN defined, STARVE_LIMIT=4, core_req_i constantly high, ctx_wr_valid_i high. Required response: ctx_wr_ack_o on the 5th arbitration; without the macro, never.
REQ-035 Sequence: mem_rvalid_i pulsed with nothing outstanding, then rst_ni pulsed. Required response: err_unexp_rvalid_o=1 after the pulse, 0 after reset.
